// File: rtl/fetch_stage_if.sv
// ---------------------------------------------------------------------------
// fetch_stage_if
//   Bundles the fetch stage's decode/execute control, its instruction-memory
//   port and its IF/ID outputs into one interface.
//
//   slave  : the fetch stage itself. It receives stall/redirect/imem data and
//            drives the imem address plus the IF/ID register outputs.
//   master : the surrounding pipeline (decode/execute stages and the imem).
//
//   Signals
//     stall_D     decode stall: hold PC and IF/ID
//     PCSrc_E     branch taken: redirect PC, flush IF/ID
//     PCBranch_E  branch target byte address (N bits)
//     imem_addr   word address to imem = PC[IMEM_AW+1:2]
//     imem_q      instruction word, combinational from imem
//     instr_D     registered instruction
//     pc_D        PC of instr_D
//     valid_D     instr_D/pc_D hold a real instruction
//     opcode_D    valid_D ? instr_D[31:21] : 0 (main decoder Op)
//     misaligned  sticky: a redirect target was not word aligned
//     halted      sticky: fetch has stopped
// ---------------------------------------------------------------------------
interface fetch_stage_if #(
    parameter int N       = 64,
    parameter int IMEM_AW = 6
);
    logic               stall_D;
    logic               PCSrc_E;
    logic [N-1:0]       PCBranch_E;
    logic [IMEM_AW-1:0] imem_addr;
    logic [31:0]        imem_q;
    logic [31:0]        instr_D;
    logic [N-1:0]       pc_D;
    logic               valid_D;
    logic [10:0]        opcode_D;
    logic               misaligned;
    logic               halted;

    modport master (
        output stall_D, PCSrc_E, PCBranch_E, imem_q,
        input  imem_addr, instr_D, pc_D, valid_D, opcode_D, misaligned, halted
    );

    modport slave (
        input  stall_D, PCSrc_E, PCBranch_E, imem_q,
        output imem_addr, instr_D, pc_D, valid_D, opcode_D, misaligned, halted
    );
endinterface

// File: rtl/fetch_stage.sv
// ---------------------------------------------------------------------------
// fetch_stage
//   LEGv8 instruction-fetch stage with the IF/ID pipeline register.
//   Holds the PC, addresses the instruction memory, registers the fetched word
//   together with its PC and a valid bit, and hands instr_D[31:21] to the main
//   decoder as opcode_D. Handles decode stalls, taken-branch redirects with
//   flush, and stops (HALT) on a misaligned redirect or an out-of-range PC.
//
//   Parameters
//     N        PC / address width
//     IMEM_AW  instruction-memory word-address bits
//     RESET_PC PC loaded on reset (word aligned)
//
//   Ports
//     clk    rising-edge clock
//     reset  asynchronous, active-low reset
//     fif    fetch_stage_if.slave (control in, imem port, IF/ID out)
// ---------------------------------------------------------------------------
module fetch_stage #(
    parameter int           N        = 64,
    parameter int           IMEM_AW  = 6,
    parameter logic [N-1:0] RESET_PC = '0
) (
    input  logic          clk,
    input  logic          reset,
    fetch_stage_if.slave  fif
);

    typedef enum logic [1:0] {
        BOOT = 2'd0,
        RUN  = 2'd1,
        HALT = 2'd2
    } state_t;

    state_t       state_q;
    logic [N-1:0] pc_q;
    logic [31:0]  instr_q;
    logic [N-1:0] pcd_q;
    logic         valid_q;
    logic         misaligned_q;
    logic         halted_q;

    logic [N-1:0] pc_inc_d;
    logic         pc_oor;
    logic         tgt_misaligned;

    // Sequential PC wraps modulo 2**N; the carry out is simply dropped.
    assign pc_inc_d = pc_q + N'(4);

    // Any PC bit above the imem word-address field means the fetch would
    // leave the memory. A shift keeps this valid for any N/IMEM_AW pairing.
    assign pc_oor = (pc_q >> (IMEM_AW + 2)) != '0;

    assign tgt_misaligned = fif.PCBranch_E[1:0] != 2'b00;

    // Single FSM block: every output-facing register is updated here so the
    // outputs stay registered and the priority order is visible in one place.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= BOOT;
            pc_q         <= RESET_PC;
            instr_q      <= '0;
            pcd_q        <= '0;
            valid_q      <= 1'b0;
            misaligned_q <= 1'b0;
            halted_q     <= 1'b0;
        end else begin
            unique case (state_q)
                // One idle edge after reset so imem sees a settled PC before
                // the first capture.
                BOOT: begin
                    state_q <= RUN;
                end

                RUN: begin
                    if (fif.PCSrc_E) begin
                        // A redirect beats a stall: the instruction in IF/ID
                        // is on the wrong path whether decode is stalled or not.
                        valid_q <= 1'b0;
                        instr_q <= '0;
                        if (tgt_misaligned) begin
                            misaligned_q <= 1'b1;
                            halted_q     <= 1'b1;
                            state_q      <= HALT;
                        end else begin
                            pc_q <= fif.PCBranch_E;
                        end
                    end else if (fif.stall_D) begin
                        // Hold everything.
                    end else if (pc_oor) begin
                        valid_q  <= 1'b0;
                        halted_q <= 1'b1;
                        state_q  <= HALT;
                    end else begin
                        instr_q <= fif.imem_q;
                        pcd_q   <= pc_q;
                        valid_q <= 1'b1;
                        pc_q    <= pc_inc_d;
                    end
                end

                // PC frozen; a valid word still waiting on a stalled decode
                // is kept until decode accepts it. Only reset leaves HALT.
                HALT: begin
                    if (!fif.stall_D) begin
                        valid_q <= 1'b0;
                    end
                end

                default: begin
                    state_q  <= HALT;
                    valid_q  <= 1'b0;
                    halted_q <= 1'b1;
                end
            endcase
        end
    end

    assign fif.imem_addr  = pc_q[IMEM_AW+1:2];
    assign fif.instr_D    = instr_q;
    assign fif.pc_D       = pcd_q;
    assign fif.valid_D    = valid_q;
    assign fif.opcode_D   = valid_q ? instr_q[31:21] : 11'b0;
    assign fif.misaligned = misaligned_q;
    assign fif.halted     = halted_q;

endmodule
